alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter FIRST_PRIO, default 0, meaning: requester with priority on the first contention after reset (0 or 1).
- REQ-002: clk  input  1  sole clock; all state changes on rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: REQ0_VALID / REQ1_VALID  input  1 each  requester n has an operation pending.
- REQ-005: REQ0_READY / REQ1_READY  output  1 each  requester n's operation is accepted this cycle.
- REQ-006: REQ0_A, REQ0_B / REQ1_A, REQ1_B  input  32 each  operands of requester n.
- REQ-007: REQ0_CTRL / REQ1_CTRL  input  4 each  ALU operation code of requester n, passed unmodified to the shared alu.
- REQ-008: RSP_VALID  output  1  result available.
- REQ-009: RSP_READY  input  1  consumer accepts the result.
- REQ-010: RSP_ID  output  1  index of the requester that owns RSP_Y.
- REQ-011: RSP_Y  output  32  ALU result.
- REQ-012: BUSY  output  1  high in any state other than IDLE.

Function
- REQ-013: The block SHALL contain exactly one alu instance, whose A/B/CTRL inputs are driven only from internal operand registers.
- REQ-014: FSM states SHALL be IDLE, EXEC, RESP.
- REQ-015: IDLE: if any REQn_VALID, grant one requester, assert its REQn_READY combinationally that cycle, latch its A/B/CTRL and ID, and go to EXEC; otherwise stay.
- REQ-016: REQn_READY SHALL be asserted only in IDLE, for at most one requester, and only while that requester's REQn_VALID is high.
- REQ-017: Arbitration: single requester valid -> it wins; both valid -> the requester not granted last wins (round-robin pointer).
- REQ-018: The round-robin pointer SHALL update only on a grant.
- REQ-019: EXEC: lasts one cycle; capture alu Y into the result register and go to RESP.
- REQ-020: RESP: RSP_VALID=1, with RSP_Y and RSP_ID from registers and stable until the handshake.
- REQ-021: RESP with RSP_READY=1 SHALL go to IDLE; otherwise stay in RESP.
- REQ-022: Latency: grant in cycle N -> RSP_VALID first high in cycle N+2; minimum initiation interval 3 cycles.
- REQ-023: Requester operands changing after grant SHALL NOT affect the in-flight result.
- REQ-024: RSP_READY high outside RESP SHALL be ignored.
- REQ-025: A requester that drops REQn_VALID before being granted SHALL simply not be granted; no state is retained for it.

Reset
- REQ-026: On rst=1 at a rising edge: state=IDLE, RSP_VALID=0, RSP_Y=0, RSP_ID=0, BUSY=0, operand registers=0, pointer set so that requester FIRST_PRIO wins the first contention.
- REQ-027: rst SHALL take priority over all other inputs; reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response.
- REQ-028: REQn_READY SHALL be 0 during any cycle in which rst=1.

Verification
- REQ-029: REQ0 A=5, B=3, CTRL=4'b0010 alone, RSP_READY=1 -> REQ0_READY in cycle N, RSP_VALID in N+2 with RSP_Y=8, RSP_ID=0.
- REQ-030: Both requesters valid continuously after reset (FIRST_PRIO=0): REQ0 A=5, B=3, CTRL=4'b0110; REQ1 A=32'hF0F0, B=32'hFF00, CTRL=4'b0000 -> responses alternate: ID0 Y=2, ID1 Y=32'h0000F000, ID0, ID1 ...
- REQ-031: RSP_READY held 0 for 5 cycles in RESP -> RSP_VALID/RSP_Y/RSP_ID stable; no REQn_READY asserted; BUSY=1.
- REQ-032: Operands changed in the cycle after grant -> RSP_Y reflects the latched operands.
- REQ-033: rst pulsed while in EXEC -> next cycle IDLE, RSP_VALID never asserted for that operation, next contention won by FIRST_PRIO.
- REQ-034: REQ1 valid alone for one grant, then both valid -> REQ0 granted next.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU.
// Requesters are granted round-robin; the winner's operands are captured,
// the ALU result is registered one cycle later and held until the consumer
// takes it.

// Shared combinational ALU.
// Operation codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
// Any other code yields zero.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] y
);

  // Decode the operation code into one result.
  always_comb begin
    y = 32'd0;
    case (ctrl)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: y = a + b;
      4'b0110: y = a - b;
      4'b0111: y = {31'd0, ($signed(a) < $signed(b))};
      4'b1100: y = ~(a | b);
      default: y = 32'd0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [31:0] REQ0_A,
  input  logic [31:0] REQ0_B,
  input  logic [3:0]  REQ0_CTRL,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [31:0] REQ1_A,
  input  logic [31:0] REQ1_B,
  input  logic [3:0]  REQ1_CTRL,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic [31:0] RSP_Y,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg;
  // Index of the requester that wins the next two-way contention.
  logic        prio_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [3:0]  ctrl_reg;
  logic        id_reg;
  logic [31:0] y_reg;
  logic        rsp_valid_reg;
  logic        busy_reg;

  logic        grant0;
  logic        grant1;
  logic [31:0] alu_y;

  // Only the captured operands feed the ALU, so requester inputs may change
  // freely once the grant has been taken.
  alu u_alu (
    .a    (a_reg),
    .b    (b_reg),
    .ctrl (ctrl_reg),
    .y    (alu_y)
  );

  // Grant decision: only in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state_reg == IDLE) begin
      if (REQ0_VALID && (!REQ1_VALID || !prio_reg)) begin
        grant0 = 1'b1;
      end else if (REQ1_VALID) begin
        grant1 = 1'b1;
      end
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign RSP_VALID  = rsp_valid_reg;
  assign RSP_ID     = id_reg;
  assign RSP_Y      = y_reg;
  assign BUSY       = busy_reg;

  // Control FSM with registered response/busy outputs and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      prio_reg      <= FIRST_PRIO;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      ctrl_reg      <= 4'd0;
      id_reg        <= 1'b0;
      y_reg         <= 32'd0;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            a_reg     <= grant1 ? REQ1_A : REQ0_A;
            b_reg     <= grant1 ? REQ1_B : REQ0_B;
            ctrl_reg  <= grant1 ? REQ1_CTRL : REQ0_CTRL;
            id_reg    <= grant1;
            // The requester not just served gets priority next time.
            prio_reg  <= grant0;
            busy_reg  <= 1'b1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          y_reg         <= alu_y;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a transaction model.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam logic FP = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_y;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction model: one operation in flight at most, described by how many
  // clock edges have passed since its grant.
  bit          m_busy;
  int          m_age;
  logic [31:0] m_y;
  bit          m_id;
  bit          m_next;   // requester that wins the next contention
  bit          m_fresh;  // no grant since reset: result outputs still zero

  alu_arbiter #(.FIRST_PRIO(FP)) dut (
    .clk        (clk),
    .rst        (rst),
    .REQ0_VALID (req0_valid),
    .REQ0_READY (req0_ready),
    .REQ0_A     (req0_a),
    .REQ0_B     (req0_b),
    .REQ0_CTRL  (req0_ctrl),
    .REQ1_VALID (req1_valid),
    .REQ1_READY (req1_ready),
    .REQ1_A     (req1_a),
    .REQ1_B     (req1_b),
    .REQ1_CTRL  (req1_ctrl),
    .RSP_VALID  (rsp_valid),
    .RSP_READY  (rsp_ready),
    .RSP_ID     (rsp_id),
    .RSP_Y      (rsp_y),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model across the next rising edge.
  task automatic step(input bit r,
                      input bit v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                      input bit v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                      input bit rr);
    bit e_r0, e_r1, e_valid;
    bit was_resp;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    rsp_ready = rr;
    #1;
    e_r0    = !r && !m_busy && v0 && (!v1 || m_next == 1'b0);
    e_r1    = !r && !m_busy && v1 && (!v0 || m_next == 1'b1);
    e_valid = m_busy && (m_age >= 2);
    check_val("ready0", {31'd0, req0_ready}, {31'd0, e_r0});
    check_val("ready1", {31'd0, req1_ready}, {31'd0, e_r1});
    check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
    check_val("busy", {31'd0, busy}, {31'd0, m_busy});
    if (e_valid || m_fresh) begin
      check_val("rsp_y", rsp_y, m_y);
      check_val("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    end
    if (r) begin
      m_busy = 0; m_age = 0; m_next = FP; m_fresh = 1; m_y = 0; m_id = 0;
    end else if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy  = 1;
        m_age   = 1;
        m_id    = e_r1;
        m_y     = e_r1 ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0);
        m_next  = e_r1 ? 1'b0 : 1'b1;
        m_fresh = 0;
      end
    end else begin
      was_resp = (m_age >= 2);
      m_age++;
      if (was_resp && rr) m_busy = 0;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  initial begin
    int k;
    logic [31:0] held_y;
    rst = 1; rsp_ready = 0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_a = 0; req1_b = 0; req1_ctrl = 0;
    repeat (2) @(posedge clk);
    m_busy = 0; m_age = 0; m_next = FP; m_fresh = 1; m_y = 0; m_id = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single requester ADD; operands change right after the grant.
    step(0, 1, 5, 3, 4'b0010, 0, 0, 0, 0, 1);
    check_val("r029_ready0", {31'd0, req0_ready}, 32'd1);
    step(0, 1, 100, 200, 4'b0110, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_val("r029_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("r029_y", rsp_y, 32'd8);
    check_val("r029_id", {31'd0, rsp_id}, 32'd0);
    idle_steps(2);

    // Both requesters continuously valid after reset: responses alternate.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    k = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 1, 5, 3, 4'b0110, 1, 32'hF0F0, 32'hFF00, 4'b0000, 1);
      if (rsp_valid === 1'b1) begin
        check_val("r030_id", {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
        check_val("r030_y", rsp_y, (k % 2 == 0) ? 32'd2 : 32'h0000F000);
        k++;
      end
    end
    check_val("r030_count", (k >= 4) ? 32'd1 : 32'd0, 32'd1);
    idle_steps(3);

    // Consumer stalls five cycles in RESP.
    step(0, 1, 9, 4, 4'b0010, 0, 0, 0, 0, 0);
    step(0, 1, 9, 4, 4'b0010, 1, 1, 1, 4'b0010, 0);
    held_y = 32'd13;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 7, 7, 4'b0010, 1, 2, 2, 4'b0010, 0);
      check_val("r031_y", rsp_y, held_y);
      check_val("r031_busy", {31'd0, busy}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_steps(2);

    // Reset during EXEC drops the operation and restores the priority.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 4'b0010, 1, 2, 2, 4'b0010, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 4'b0010, 1, 2, 2, 4'b0010, 1);
    check_val("r033_grant1", {31'd0, req1_ready}, 32'd1);
    step(1, 1, 1, 1, 4'b0010, 1, 2, 2, 4'b0010, 1);
    check_val("r033_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    step(0, 1, 1, 1, 4'b0010, 1, 2, 2, 4'b0010, 1);
    check_val("r033_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("r033_grant0", {31'd0, req0_ready}, 32'd1);
    idle_steps(3);

    // REQ1 alone, then contention: REQ0 next.
    step(0, 0, 0, 0, 0, 1, 6, 2, 4'b0110, 1);
    check_val("r034_grant1", {31'd0, req1_ready}, 32'd1);
    idle_steps(2);
    step(0, 1, 3, 3, 4'b0010, 1, 4, 4, 4'b0010, 1);
    check_val("r034_grant0", {31'd0, req0_ready}, 32'd1);
    idle_steps(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int s0, s1;
      logic [3:0] c0, c1;
      s0 = $urandom_range(0, 6);
      s1 = $urandom_range(0, 6);
      c0 = (s0 == 6) ? 4'($urandom) : codes[s0];
      c1 = (s1 == 6) ? 4'($urandom) : codes[s1];
      step($urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 60, $urandom, $urandom, c0,
           $urandom_range(0, 99) < 60, $urandom, $urandom, c1,
           $urandom_range(0, 99) < 65);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
